// File: rtl/uart_rx_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_gen_if
// Brief    : Serial-line, oversample-tick and CPU status bundle of uart_rx_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_gen_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic                 en_rx;
    logic                 over_read;
    logic [DATA_BITS-1:0] d_out;
    logic                 rs;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    // Pad / tick generator / CPU side
    modport master (
        output rxd, en_rx, over_read,
        input  d_out, rs, frame_err, parity_err, overrun_err
    );

    // Receiver side
    modport slave (
        input  rxd, en_rx, over_read,
        output d_out, rs, frame_err, parity_err, overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_gen
// Brief    : Oversampling UART receiver with parity, stop-bit and overrun
//            checking. Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_gen #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  wire logic    clk,
    input  wire logic    rst,
    uart_rx_gen_if.slave bus
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_BIT  = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_BIT  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_DATA = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_STOP = c_BIT_W'(STOP_BITS - 1);
    localparam logic               c_ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } t_state;

    logic                 r_rxd_meta;
    logic                 r_rxs;
    logic                 w_sample;

    t_state               r_state;
    t_state               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt_sample;
    logic [c_CNT_W-1:0]   w_cnt_sample_nxt;
    logic [c_BIT_W-1:0]   r_cnt_bits;
    logic [c_BIT_W-1:0]   w_cnt_bits_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par_pend;
    logic                 w_par_pend_nxt;
    logic                 r_stop_bad;
    logic                 w_stop_bad_nxt;
    logic                 w_stop_bad_now;
    logic                 w_par_exp;
    logic                 w_done;
    logic                 w_done_bad;

    logic                 r_done;
    logic                 r_done_bad;
    logic                 r_done_pend;

    logic [DATA_BITS-1:0] r_d_out;
    logic                 r_rs;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxs      <= 1'b1;
        end else begin
            r_rxd_meta <= bus.rxd;
            r_rxs      <= r_rxd_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // History of rxs at the two previous ticks; the sample point is the third.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (bus.en_rx) begin
            r_hist <= {r_hist[0], r_rxs};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) |
                      (r_hist[1] & r_rxs)     |
                      (r_hist[0] & r_rxs);
`else
    assign w_sample = r_rxs;
`endif

    assign w_par_exp = (^r_shift) ^ c_ODD;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt_sample <= '0;
            r_cnt_bits   <= '0;
            r_shift      <= '0;
            r_par_pend   <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_done       <= 1'b0;
            r_done_bad   <= 1'b0;
            r_done_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt_sample <= w_cnt_sample_nxt;
            r_cnt_bits   <= w_cnt_bits_nxt;
            r_shift      <= w_shift_nxt;
            r_par_pend   <= w_par_pend_nxt;
            r_stop_bad   <= w_stop_bad_nxt;
            r_done       <= w_done;
            r_done_bad   <= w_done_bad;
            r_done_pend  <= r_par_pend;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_sample_nxt = r_cnt_sample;
        w_cnt_bits_nxt   = r_cnt_bits;
        w_shift_nxt      = r_shift;
        w_par_pend_nxt   = r_par_pend;
        w_stop_bad_nxt   = r_stop_bad;
        w_stop_bad_now   = r_stop_bad | ~w_sample;
        w_done           = 1'b0;
        w_done_bad       = 1'b0;

        if (bus.en_rx) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        w_cnt_sample_nxt = '0;
                        w_state_nxt      = S_START;
                    end
                end

                S_START: begin
                    if (r_cnt_sample == c_HALF_BIT) begin
                        if (w_sample) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_sample_nxt = '0;
                            w_cnt_bits_nxt   = '0;
                            w_par_pend_nxt   = 1'b0;
                            w_stop_bad_nxt   = 1'b0;
                            w_state_nxt      = S_DATA;
                        end
                    end else begin
                        w_cnt_sample_nxt = r_cnt_sample + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt_sample == c_FULL_BIT) begin
                        w_cnt_sample_nxt = '0;
                        w_shift_nxt      = {w_sample, r_shift[DATA_BITS-1:1]};
                        if (r_cnt_bits == c_LAST_DATA) begin
                            w_cnt_bits_nxt = '0;
                            w_state_nxt    = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            w_cnt_bits_nxt = r_cnt_bits + 1'b1;
                        end
                    end else begin
                        w_cnt_sample_nxt = r_cnt_sample + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (r_cnt_sample == c_FULL_BIT) begin
                        w_cnt_sample_nxt = '0;
                        w_par_pend_nxt   = (w_sample != w_par_exp);
                        w_state_nxt      = S_STOP;
                    end else begin
                        w_cnt_sample_nxt = r_cnt_sample + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_cnt_sample == c_FULL_BIT) begin
                        w_cnt_sample_nxt = '0;
                        w_stop_bad_nxt   = w_stop_bad_now;
                        if (r_cnt_bits == c_LAST_STOP) begin
                            w_cnt_bits_nxt = '0;
                            w_done         = 1'b1;
                            w_done_bad     = w_stop_bad_now;
                            w_state_nxt    = w_stop_bad_now ? S_WAIT_IDLE : S_IDLE;
                        end else begin
                            w_cnt_bits_nxt = r_cnt_bits + 1'b1;
                        end
                    end else begin
                        w_cnt_sample_nxt = r_cnt_sample + 1'b1;
                    end
                end

                S_WAIT_IDLE: begin
                    if (r_rxs) begin
                        w_state_nxt = S_IDLE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Completion takes priority over a coincident CPU read; a word still
    // unread when the next one lands keeps rs set and raises overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out       <= '0;
            r_rs          <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else if (r_done) begin
            r_d_out       <= r_shift;
            r_rs          <= ~r_done_bad | (r_rs & ~bus.over_read);
            r_frame_err   <= r_done_bad;
            r_parity_err  <= r_done_pend;
            r_overrun_err <= (r_rs | r_overrun_err) & ~bus.over_read;
        end else if (bus.over_read) begin
            r_rs          <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end
    end

    assign bus.d_out       = r_d_out;
    assign bus.rs          = r_rs;
    assign bus.frame_err   = r_frame_err;
    assign bus.parity_err  = r_parity_err;
    assign bus.overrun_err = r_overrun_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_gen.sv
`default_nettype none
// Bench for uart_rx_gen: an 8N1/x8 and an 8E2/x16 receiver fed with per-tick
// line waveforms; expected words go into queues checked by per-DUT monitors.
module tb_uart_rx_gen;

    localparam int DB = 8;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        logic       fe;
        logic       pe;
        logic       ov;
        longint     due;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     nvec = 0;
    int     nerr = 0;
    bit     hold0 = 1'b0;
    bit     hold1 = 1'b0;
    exp_t   q0[$];
    exp_t   q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_gen_if #(.DATA_BITS(DB)) b0 ();
    uart_rx_gen_if #(.DATA_BITS(DB)) b1 ();

    uart_rx_gen #(.DATA_BITS(DB), .OVERSAMPLE(8), .STOP_BITS(1), .PARITY(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    uart_rx_gen #(.DATA_BITS(DB), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Shared oversample tick: one pulse every 4 clocks.
    initial begin
        b0.en_rx = 1'b0;
        b1.en_rx = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            b0.en_rx = 1'b1;
            b1.en_rx = 1'b1;
            @(negedge clk);
            b0.en_rx = 1'b0;
            b1.en_rx = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required run completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int os_of(input int k);  return (k == 0) ? 8 : 16; endfunction
    function automatic int sb_of(input int k);  return (k == 0) ? 1 : 2;  endfunction
    function automatic int par_of(input int k); return (k == 0) ? 0 : 1;  endfunction

    function automatic logic [7:0] get_d(input int k);
        return (k == 0) ? b0.d_out : b1.d_out;
    endfunction

    function automatic logic [3:0] get_f(input int k);
        if (k == 0) return {b0.rs, b0.frame_err, b0.parity_err, b0.overrun_err};
        return {b1.rs, b1.frame_err, b1.parity_err, b1.overrun_err};
    endfunction

    function automatic bit held(input int k);
        return (k == 0) ? hold0 : hold1;
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic exp_t qpop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic set_rxd(input int k, input logic v);
        if (k == 0) b0.rxd = v;
        else        b1.rxd = v;
    endtask

    task automatic set_rd(input int k, input logic v);
        if (k == 0) b0.over_read = v;
        else        b1.over_read = v;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (b0.en_rx !== 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int k, input int n);
        set_rxd(k, 1'b1);
        repeat (n) wait_tick();
    endtask

    // Build the line waveform one tick per entry, drive it, and queue the
    // expected result when the last stop bit's mid-point is reached.
    task automatic send_frame(input int k, input logic [7:0] d, input bit pflip,
                              input int bad_stop, input int glitch_j, input bit push,
                              input bit rd_at_cmp, input bit ov_exp, input logic [7:0] d_exp);
        int   os;
        int   jl;
        logic pb;
        logic v;
        logic w[$];
        exp_t e;
        os = os_of(k);
        w  = {};
        repeat (os) w.push_back(1'b0);
        for (int i = 0; i < DB; i++) repeat (os) w.push_back(d[i]);
        if (par_of(k) != 0) begin
            pb = (^d) ^ (par_of(k) == 2) ^ pflip;
            repeat (os) w.push_back(pb);
        end
        for (int s = 0; s < sb_of(k); s++) begin
            v = (s == bad_stop) ? 1'b0 : 1'b1;
            repeat (os) w.push_back(v);
        end
        if (glitch_j >= 0) w[glitch_j] = ~w[glitch_j];
        jl = os / 2 + os * (DB + ((par_of(k) != 0) ? 1 : 0) + sb_of(k));
        for (int j = 0; j < w.size(); j++) begin
            set_rxd(k, w[j]);
            wait_tick();
            if (j == jl) begin
                if (push) begin
                    e.d   = d_exp;
                    e.rs  = (bad_stop < 0);
                    e.fe  = (bad_stop >= 0);
                    e.pe  = (par_of(k) != 0) && pflip;
                    e.ov  = ov_exp;
                    e.due = (held(k) || rd_at_cmp) ? -1 : cyc + 1;
                    qpush(k, e);
                end
                if (rd_at_cmp) begin
                    set_rd(k, 1'b1);
                    @(negedge clk);
                    set_rd(k, 1'b0);
                end
            end
        end
    endtask

    task automatic monitor(input int k);
        exp_t       e;
        logic [3:0] f;
        forever begin
            @(negedge clk);
            f = get_f(k);
            if (!held(k) && !rst && (f[3] || f[2])) begin
                if (qsize(k) == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL dut%0d unexpected_word: got d_out=%0h flags=%b, required no word",
                             k, get_d(k), f);
                end else begin
                    e = qpop(k);
                    chk($sformatf("dut%0d d_out", k), get_d(k), e.d);
                    chk($sformatf("dut%0d rs", k), f[3], e.rs);
                    chk($sformatf("dut%0d frame_err", k), f[2], e.fe);
                    chk($sformatf("dut%0d parity_err", k), f[1], e.pe);
                    chk($sformatf("dut%0d overrun_err", k), f[0], e.ov);
                    if (e.due >= 0) chk($sformatf("dut%0d latency_cycle", k), cyc, e.due);
                end
                set_rd(k, 1'b1);
                @(negedge clk);
                set_rd(k, 1'b0);
            end
        end
    endtask

    logic [7:0] maj_exp;
    logic [7:0] rd;
    bit         pf;
    int         bs;

    initial begin
`ifdef UART_RX_MAJORITY_EN
        maj_exp = 8'h00;
`else
        maj_exp = 8'h08;
`endif
        b0.rxd = 1'b1;  b1.rxd = 1'b1;
        b0.over_read = 1'b0;  b1.over_read = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d reset d_out", k), get_d(k), 8'h00);
            chk($sformatf("dut%0d reset flags", k), get_f(k), 4'b0000);
        end
        fork
            monitor(0);
            monitor(1);
        join_none

        // 8N1 word, then read-back clears status
        idle(0, 4);
        send_frame(0, 8'hA5, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0, 8'hA5);
        idle(0, 4);
        chk("dut0 flags after read", get_f(0), 4'b0000);

        // Two-tick start glitch is rejected
        set_rxd(0, 1'b0);
        wait_tick();
        wait_tick();
        idle(0, 20);
        chk("dut0 glitch flags", get_f(0), 4'b0000);
        chk("dut0 glitch d_out", get_d(0), 8'hA5);

        // Stop bit low: frame error, then line held low must not restart
        send_frame(0, 8'h3C, 1'b0, 0, -1, 1'b1, 1'b0, 1'b0, 8'h3C);
        set_rxd(0, 1'b0);
        repeat (100) wait_tick();
        idle(0, 4);
        chk("dut0 flags after wait_idle", get_f(0), 4'b0000);

        // Overrun, then the same with a read coinciding with completion
        hold0 = 1'b1;
        send_frame(0, 8'h11, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 8'h11);
        idle(0, 2);
        send_frame(0, 8'h22, 1'b0, -1, -1, 1'b1, 1'b0, 1'b1, 8'h22);
        hold0 = 1'b0;
        idle(0, 4);
        hold0 = 1'b1;
        send_frame(0, 8'h11, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, 8'h11);
        idle(0, 2);
        send_frame(0, 8'h22, 1'b0, -1, -1, 1'b1, 1'b1, 1'b0, 8'h22);
        hold0 = 1'b0;
        idle(0, 4);

        // One-tick high glitch exactly at the bit-3 sample point
        send_frame(0, 8'h00, 1'b0, -1, 4 + 8 * 4, 1'b1, 1'b0, 1'b0, maj_exp);
        idle(0, 4);

        // Even parity on the x16 / 2-stop receiver
        idle(1, 4);
        send_frame(1, 8'h5A, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0, 8'h5A);
        idle(1, 4);
        send_frame(1, 8'h5A, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0, 8'h5A);
        idle(1, 4);

        // Randomised frames, some with parity or stop errors, varied gaps
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 20; n++) begin
                rd = 8'($urandom_range(0, 255));
                pf = (par_of(k) != 0) && ($urandom_range(0, 3) == 0);
                bs = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sb_of(k) - 1)) : -1;
                send_frame(k, rd, pf, bs, -1, 1'b1, 1'b0, 1'b0, rd);
                idle(k, (bs >= 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3)));
            end
            idle(k, 4);
        end

        for (int i = 0; i < 2000 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
        chk("scoreboard words outstanding", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
